// File: rtl/adder_pkg.sv
// -----------------------------------------------------------------------------
// adder_pkg
//   Shared definitions for the pipelined add/subtract/accumulate unit.
//   - op_e         : 2-bit operation encoding carried through the pipeline
//   - op_writes_acc: true for operations that update the running accumulator
// -----------------------------------------------------------------------------
package adder_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_ACC = 2'b10,
        OP_CLR = 2'b11
    } op_e;

    // ACC and CLR are the only operations that own the accumulator.
    function automatic logic op_writes_acc(input op_e op);
        return (op == OP_ACC) || (op == OP_CLR);
    endfunction

endpackage

// File: rtl/adder_alu.sv
// -----------------------------------------------------------------------------
// adder_alu
//   Purely combinational compute slice used by stage 2 of adder_pipe_acc.
//   All arithmetic is done at WIDTH+1 bits so the carry/borrow falls out of
//   the top bit.
//
//   Parameters
//     WIDTH    operand/result width (>= 2)
//     SAT      1 = unsigned saturation, 0 = wrap-around
//
//   Ports
//     op        operation (ADD/SUB/ACC/CLR)
//     a, b      registered operands from stage 1 (b unused for ACC/CLR)
//     acc       current accumulator value
//     sum       result (after optional saturation)
//     cout      carry for ADD/ACC, borrow for SUB, 0 for CLR
//     acc_next  value the accumulator takes if acc_we is set
//     acc_we    accumulator write request (ACC or CLR)
// -----------------------------------------------------------------------------
module adder_alu
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned SAT   = 0
) (
    input  op_e              op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] acc,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic [WIDTH-1:0] acc_next,
    output logic             acc_we
);

    logic [WIDTH-1:0] add_lhs;
    logic [WIDTH-1:0] add_rhs;
    logic [WIDTH:0]   add_full;
    logic [WIDTH:0]   sub_full;

    // ACC shares the adder with ADD: the accumulator replaces operand A and
    // operand A takes the place of B.
    always_comb begin
        add_lhs = a;
        add_rhs = b;
        if (op == OP_ACC) begin
            add_lhs = acc;
            add_rhs = a;
        end
    end

    assign add_full = {1'b0, add_lhs} + {1'b0, add_rhs};
    // Top bit of the extended difference is set exactly when a < b.
    assign sub_full = {1'b0, a} - {1'b0, b};

    always_comb begin
        sum  = '0;
        cout = 1'b0;
        unique case (op)
            OP_ADD, OP_ACC: begin
                cout = add_full[WIDTH];
                sum  = add_full[WIDTH-1:0];
                if ((SAT != 0) && add_full[WIDTH]) begin
                    sum = '1;
                end
            end
            OP_SUB: begin
                cout = sub_full[WIDTH];
                sum  = sub_full[WIDTH-1:0];
                if ((SAT != 0) && sub_full[WIDTH]) begin
                    sum = '0;
                end
            end
            OP_CLR: begin
                sum  = '0;
                cout = 1'b0;
            end
        endcase
    end

    // The accumulator tracks the (possibly saturated) ACC result.
    always_comb begin
        acc_we   = op_writes_acc(op);
        acc_next = acc;
        if (op == OP_ACC) begin
            acc_next = sum;
        end else if (op == OP_CLR) begin
            acc_next = '0;
        end
    end

endmodule

// File: rtl/adder_pipe_acc.sv
// -----------------------------------------------------------------------------
// adder_pipe_acc
//   Two-stage pipelined unsigned add/subtract/accumulate unit with a
//   valid/ready handshake on both sides and optional saturation.
//
//   Stage 1 registers the operands and op; stage 2 computes through
//   adder_alu and registers the result, carry and accumulator.
//
//   Parameters
//     WIDTH    operand, result and accumulator width (>= 2)
//     SAT      1 = unsigned saturating results, 0 = wrap-around
//
//   Ports
//     clk        clock, rising edge
//     rst        asynchronous reset, active low
//     in_valid   producer has an operation
//     in_ready   stage 1 can accept this cycle (combinational from out_ready)
//     in_a       operand A
//     in_b       operand B (ignored for ACC/CLR)
//     in_op      00 ADD, 01 SUB, 10 ACC, 11 CLR
//     out_valid  result is valid
//     out_ready  consumer accepts the result
//     out_sum    result
//     out_cout   carry (ADD/ACC) or borrow (SUB); 0 for CLR
//     acc_q      current accumulator value
// -----------------------------------------------------------------------------
module adder_pipe_acc
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned SAT   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [1:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic [WIDTH-1:0] acc_q
);

    // Stage 1 state
    logic             v1_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    op_e              op_q;

    // Stage 2 state
    logic             out_valid_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;

    // Handshake
    logic s2_load;
    logic s1_load;

    // ALU results
    logic [WIDTH-1:0] alu_sum;
    logic             alu_cout;
    logic [WIDTH-1:0] alu_acc_next;
    logic             alu_acc_we;

    // Stage 2 advances when empty or drained this cycle; stage 1 advances
    // when empty or when its content moves into stage 2. No skid buffer, so
    // backpressure reaches in_ready combinationally.
    assign s2_load  = !out_valid_q || out_ready;
    assign s1_load  = !v1_q || s2_load;
    assign in_ready = s1_load;

    // -------------------------------------------------------------------------
    // Stage 1: operand registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1_q <= 1'b0;
            a_q  <= '0;
            b_q  <= '0;
            op_q <= OP_ADD;
        end else if (s1_load) begin
            v1_q <= in_valid;
            // Operands only matter alongside valid; skip the load otherwise.
            if (in_valid) begin
                a_q  <= in_a;
                b_q  <= in_b;
                op_q <= op_e'(in_op);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Stage 2: compute
    // -------------------------------------------------------------------------
    adder_alu #(
        .WIDTH (WIDTH),
        .SAT   (SAT)
    ) u_alu (
        .op       (op_q),
        .a        (a_q),
        .b        (b_q),
        .acc      (acc_q),
        .sum      (alu_sum),
        .cout     (alu_cout),
        .acc_next (alu_acc_next),
        .acc_we   (alu_acc_we)
    );

    // -------------------------------------------------------------------------
    // Stage 2: result and accumulator registers
    // -------------------------------------------------------------------------
    // The accumulator is written only at the edge where an ACC/CLR moves from
    // stage 1 into stage 2. A stalled result is not reloaded, so an ACC sitting
    // in stage 2 cannot be applied twice; an ACC stuck in stage 1 has not been
    // applied yet. Back-to-back ACCs therefore see each other's result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            acc_q       <= '0;
        end else if (s2_load) begin
            out_valid_q <= v1_q;
            if (v1_q) begin
                sum_q  <= alu_sum;
                cout_q <= alu_cout;
                if (alu_acc_we) begin
                    acc_q <= alu_acc_next;
                end
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = sum_q;
    assign out_cout  = cout_q;

endmodule

// File: tb/tb_adder_pipe_acc.sv
// -----------------------------------------------------------------------------
// tb_adder_pipe_acc
//   Directed bench. Three instances share clock, reset and handshake inputs:
//     d4  : WIDTH=4,  SAT=0
//     s4  : WIDTH=4,  SAT=1
//     w16 : WIDTH=16, SAT=0
//   Narrow instances see the low 4 bits of the operands.
// -----------------------------------------------------------------------------
module tb_adder_pipe_acc;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [1:0]  in_op;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        out_ready;

    logic        rdy_d4, rdy_s4, rdy_w16;
    logic        ov_d4, ov_s4, ov_w16;
    logic [3:0]  sum_d4, sum_s4;
    logic [15:0] sum_w16;
    logic        co_d4, co_s4, co_w16;
    logic [3:0]  acc_d4, acc_s4;
    logic [15:0] acc_w16;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    adder_pipe_acc #(.WIDTH(4), .SAT(0)) u_d4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_d4),
        .in_a(in_a[3:0]), .in_b(in_b[3:0]), .in_op(in_op),
        .out_valid(ov_d4), .out_ready(out_ready), .out_sum(sum_d4),
        .out_cout(co_d4), .acc_q(acc_d4)
    );

    adder_pipe_acc #(.WIDTH(4), .SAT(1)) u_s4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_s4),
        .in_a(in_a[3:0]), .in_b(in_b[3:0]), .in_op(in_op),
        .out_valid(ov_s4), .out_ready(out_ready), .out_sum(sum_s4),
        .out_cout(co_s4), .acc_q(acc_s4)
    );

    adder_pipe_acc #(.WIDTH(16), .SAT(0)) u_w16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_w16),
        .in_a(in_a), .in_b(in_b), .in_op(in_op),
        .out_valid(ov_w16), .out_ready(out_ready), .out_sum(sum_w16),
        .out_cout(co_w16), .acc_q(acc_w16)
    );

    task automatic check_val(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [2:0]  mask;   // bit0 d4, bit1 s4, bit2 w16
        logic [15:0] s0;
        logic        c0;
        logic [15:0] s1;
        logic        c1;
        logic [15:0] s2;
        logic        c2;
    } vec_t;

    function automatic vec_t mk(input logic [1:0] op, input logic [15:0] a,
                                input logic [15:0] b, input logic [2:0] mask,
                                input logic [15:0] s0, input logic c0,
                                input logic [15:0] s1, input logic c1,
                                input logic [15:0] s2, input logic c2);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.mask = mask;
        v.s0 = s0; v.c0 = c0; v.s1 = s1; v.c1 = c1; v.s2 = s2; v.c2 = c2;
        return v;
    endfunction

    vec_t vecs[9];

    // Backpressure stream: 5 ADDs, CLR, ACC 6 (d4 results)
    logic [1:0]  p_op[7]  = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b10};
    logic [15:0] p_a[7]   = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd0, 16'd6};
    logic [15:0] p_b[7]   = '{16'd0, 16'd2, 16'd4, 16'd6, 16'd8, 16'd0, 16'd0};
    logic [3:0]  p_exp[7] = '{4'd1, 4'd4, 4'd7, 4'd10, 4'd13, 4'd0, 4'd6};
    logic        pat[4]   = '{1'b1, 1'b0, 1'b0, 1'b1};
    int          stall_seen = 0;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = mk(2'b00, 16'd7,     16'd5,     3'b001, 16'd12, 1'b0, 16'd0,  1'b0,
                     16'd0,  1'b0);
        vecs[1] = mk(2'b00, 16'd9,     16'd8,     3'b011, 16'd1,  1'b1, 16'd15, 1'b1,
                     16'd0,  1'b0);
        vecs[2] = mk(2'b01, 16'd3,     16'd5,     3'b011, 16'd14, 1'b1, 16'd0,  1'b1,
                     16'd0,  1'b0);
        vecs[3] = mk(2'b11, 16'd0,     16'd0,     3'b111, 16'd0,  1'b0, 16'd0,  1'b0,
                     16'd0,  1'b0);
        vecs[4] = mk(2'b10, 16'd3,     16'd0,     3'b111, 16'd3,  1'b0, 16'd3,  1'b0,
                     16'd3,  1'b0);
        vecs[5] = mk(2'b10, 16'd4,     16'd0,     3'b111, 16'd7,  1'b0, 16'd7,  1'b0,
                     16'd7,  1'b0);
        vecs[6] = mk(2'b10, 16'd10,    16'd0,     3'b111, 16'd1,  1'b1, 16'd15, 1'b1,
                     16'd17, 1'b0);
        vecs[7] = mk(2'b00, 16'hFFFF,  16'h0001,  3'b101, 16'd0,  1'b1, 16'd0,  1'b0,
                     16'd0,  1'b1);
        vecs[8] = mk(2'b01, 16'h1234,  16'h0234,  3'b101, 16'd0,  1'b0, 16'd0,  1'b0,
                     16'h1000, 1'b0);

        // ---------------- reset state ----------------
        rst = 1'b0; in_valid = 1'b0; in_op = 2'b00; in_a = '0; in_b = '0;
        out_ready = 1'b1;
        #1;
        check_val("rst_out_valid", ov_d4, 0);
        check_val("rst_out_sum", sum_d4, 0);
        check_val("rst_out_cout", co_d4, 0);
        check_val("rst_acc", acc_d4, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_val("rst_in_ready", rdy_d4, 1);

        // ---------------- unstalled directed stream ----------------
        for (int j = 0; j <= 10; j++) begin
            @(posedge clk); #1;
            if (j >= 2) begin
                vec_t v;
                v = vecs[j-2];
                check_val($sformatf("v%0d_valid", j-2), ov_d4, 1);
                if (v.mask[0]) begin
                    check_val($sformatf("v%0d_d4_sum", j-2), sum_d4, v.s0);
                    check_val($sformatf("v%0d_d4_cout", j-2), co_d4, v.c0);
                end
                if (v.mask[1]) begin
                    check_val($sformatf("v%0d_s4_sum", j-2), sum_s4, v.s1);
                    check_val($sformatf("v%0d_s4_cout", j-2), co_s4, v.c1);
                end
                if (v.mask[2]) begin
                    check_val($sformatf("v%0d_w16_sum", j-2), sum_w16, v.s2);
                    check_val($sformatf("v%0d_w16_cout", j-2), co_w16, v.c2);
                end
            end else begin
                check_val($sformatf("lat_idle_%0d", j), ov_d4, 0);
            end
            if (j < 9) begin
                in_valid = 1'b1; in_op = vecs[j].op; in_a = vecs[j].a; in_b = vecs[j].b;
            end else begin
                in_valid = 1'b0;
            end
        end
        check_val("acc_end_d4", acc_d4, 1);
        check_val("acc_end_s4", acc_s4, 15);
        check_val("acc_end_w16", acc_w16, 17);
        @(posedge clk); #1;
        check_val("drain_valid", ov_d4, 0);

        // ---------------- backpressure ----------------
        fork
            begin : producer
                int  tries;
                bit  done;
                for (int i = 0; i < 7; i++) begin
                    in_valid = 1'b1; in_op = p_op[i]; in_a = p_a[i]; in_b = p_b[i];
                    tries = 0; done = 1'b0;
                    while (!done && tries < 50) begin
                        @(negedge clk);
                        if (rdy_d4) done = 1'b1;
                        else stall_seen++;
                        @(posedge clk); #1;
                        tries++;
                    end
                    check_val($sformatf("bp_push%0d", i), done, 1);
                end
                in_valid = 1'b0;
            end
            begin : consumer
                int          got;
                int          cyc;
                bit          prev_stall;
                logic [3:0]  prev_sum;
                got = 0; cyc = 0; prev_stall = 1'b0; prev_sum = '0;
                while (got < 7 && cyc < 200) begin
                    @(posedge clk); #1;
                    out_ready = pat[cyc % 4];
                    cyc++;
                    @(negedge clk);
                    if (prev_stall) begin
                        check_val("bp_hold_valid", ov_d4, 1);
                        check_val("bp_hold_sum", sum_d4, prev_sum);
                    end
                    if (ov_d4 && out_ready) begin
                        check_val($sformatf("bp_res%0d", got), sum_d4, p_exp[got]);
                        check_val($sformatf("bp_cout%0d", got), co_d4, 0);
                        got++;
                    end
                    prev_stall = ov_d4 && !out_ready;
                    prev_sum   = sum_d4;
                end
                check_val("bp_count", got, 7);
            end
        join
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_val("bp_no_extra", ov_d4, 0);
        check_val("bp_acc_once", acc_d4, 6);
        check_val("bp_in_ready_dropped", stall_seen != 0, 1);

        // ---------------- reset with both stages full ----------------
        out_ready = 1'b0; in_valid = 1'b1; in_op = 2'b00; in_a = 16'd1; in_b = 16'd2;
        @(posedge clk); #1;
        in_a = 16'd3; in_b = 16'd3;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check_val("full_in_ready", rdy_d4, 0);
        check_val("full_sum", sum_d4, 3);
        #2;
        rst = 1'b0;
        #1;
        check_val("mid_rst_valid", ov_d4, 0);
        check_val("mid_rst_sum", sum_d4, 0);
        check_val("mid_rst_acc", acc_d4, 0);
        check_val("mid_rst_in_ready", rdy_d4, 1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b1; in_valid = 1'b1; in_op = 2'b00; in_a = 16'd2; in_b = 16'd2;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check_val("post_rst_lat1", ov_d4, 0);
        @(posedge clk); #1;
        check_val("post_rst_valid", ov_d4, 1);
        check_val("post_rst_sum", sum_d4, 4);
        @(posedge clk); #1;
        check_val("post_rst_drain", ov_d4, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
